edge_delay_meter: RTL and testbench
===================================

# edge_delay_meter

Clocked measurement block that times the propagation delay of a gate or path under test. It watches the launch signal driven into the path and the response coming back, counts clock cycles from each launch edge to the matching response edge, and classifies the delay as rise or fall. Each delay is checked against separate rise and fall min/max windows. It sits on the observing end of the delay-modelled gate benches and gives them a synthesizable pass/fail monitor for min:typ:max rise/fall characterisation.

## Interface
- CW, 8, counter and delay width
- RISE_MIN, 3, minimum legal rise delay (cycles)
- RISE_MAX, 7, maximum legal rise delay
- FALL_MIN, 1, minimum legal fall delay
- FALL_MAX, 4, maximum legal fall delay
- TIMEOUT, 255, cycles without response before giving up (≤ 2^CW−1)
- INVERT, 0, 1 = path is inverting; expected response = launch value XOR INVERT

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  measurement enable
- stim  in  1  launch signal driven into path (synchronous to clk)
- resp  in  1  path response (synchronous to clk)
- busy  out  1  measurement in progress
- meas_valid  out  1  one-cycle result strobe
- meas_delay  out  CW  measured delay in cycles
- meas_rise  out  1  1 = expected response was 1 (rise), 0 = fall
- meas_pass  out  1  delay inside window for its direction
- meas_timeout  out  1  result ended by timeout
- meas_abort  out  1  result ended by a new launch edge before response
- rise_worst  out  CW  largest completed rise delay since reset
- fall_worst  out  CW  largest completed fall delay since reset
- err_cnt  out  8  count of failing results, saturating at 255

## Operation
- States: IDLE, MEAS.
- stim_q samples stim every edge. After reset, the first sample only primes stim_q and never launches.
- Launch = en & primed & (stim != stim_q). On launch: exp <= stim ^ INVERT, cnt <= 0, state MEAS.
- MEAS, each edge: cnt <= cnt+1. If resp == exp, the result is delay = cnt+1. A response already matching at the first MEAS edge gives delay 1.
- Match: pass = (exp ? RISE_MIN≤d≤RISE_MAX : FALL_MIN≤d≤FALL_MAX).
  - Update the worst register for the direction if d exceeds it.
  - Return to IDLE.
- Timeout: cnt+1 == TIMEOUT with no match.
  - Report delay=TIMEOUT, timeout=1, pass=0.
  - Worst registers are not updated.
  - Return to IDLE.
- New stim edge while in MEAS, no match on the same edge: report abort=1, pass=0, delay=cnt+1. Relaunch immediately with the new exp and cnt <= 0, staying in MEAS.
- New stim edge and match on the same edge: report the normal match result, then relaunch as above. Match takes priority over abort; the new edge is never lost.
- Timeout and a new stim edge on the same edge: report abort, then relaunch.
- en low in MEAS: drop to IDLE on the next edge with no report. en low in IDLE: no launches, but stim_q keeps tracking.
- err_cnt increments on every meas_valid with meas_pass=0 and holds at 255.

## Timing
- Reset values: state IDLE, primed=0, stim_q=0, and all outputs 0.
- All outputs are registered.
- meas_valid is high for exactly the one cycle after the deciding edge.
- meas_delay, meas_rise, meas_pass, meas_timeout and meas_abort update with meas_valid and hold until the next meas_valid.
- busy = (state == MEAS) and is high from the edge after launch.
- Minimum reportable delay is 1. Results can be back-to-back on every cycle during relaunch.
- Reset asserted mid-measurement clears everything immediately, with no result reported.

## Test plan
- INVERT=0, stim 0→1 at edge k, resp 0→1 at edge k+5 -> one meas_valid with delay=5, rise=1, pass=1; rise_worst=5.
- stim 1→0, resp falls 2 cycles later -> delay=2, rise=0, pass=1. Repeat with a 6-cycle fall -> pass=0, err_cnt=1, fall_worst=6.
- stim rises, resp stuck at 0, TIMEOUT=20 -> meas_valid at 20 cycles with timeout=1, delay=20, pass=0; busy drops; rise_worst unchanged.
- stim 0→1, then stim 1→0 three cycles later with no response -> abort=1, delay=3. Measurement continues as a fall with exp=0; resp already 0 -> next valid delay=1, rise=0.
- INVERT=1, stim 0→1, resp 1→0 after 2 cycles -> rise=0, delay=2, pass=1. Drop en mid-measurement -> no valid, busy=0 next cycle.
- Assert rst_n low during MEAS -> all outputs 0 immediately. stim held at 1 across reset release -> no launch.

Source files
------------

// File: rtl/edge_delay_meter.sv
// edge_delay_meter: times launch-to-response delay of a path under test and
// checks each rise/fall delay against its own min/max window.
module edge_delay_meter #(
    parameter int CW       = 8,
    parameter int RISE_MIN = 3,
    parameter int RISE_MAX = 7,
    parameter int FALL_MIN = 1,
    parameter int FALL_MAX = 4,
    parameter int TIMEOUT  = 255,
    parameter bit INVERT   = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          stim_i,
    input  logic          resp_i,
    output logic          busy_o,
    output logic          meas_valid_o,
    output logic [CW-1:0] meas_delay_o,
    output logic          meas_rise_o,
    output logic          meas_pass_o,
    output logic          meas_timeout_o,
    output logic          meas_abort_o,
    output logic [CW-1:0] rise_worst_o,
    output logic [CW-1:0] fall_worst_o,
    output logic [7:0]    err_cnt_o
);
    typedef enum logic {IDLE, MEAS} state_t;

    state_t        state_q;
    logic          primed_q, stim_q, exp_q;
    logic [CW-1:0] cnt_q;
    logic          valid_q, rise_q, pass_q, timeout_q, abort_q;
    logic [CW-1:0] delay_q, rise_worst_q, fall_worst_q;
    logic [7:0]    err_cnt_q;

    logic          launch, match, tmo, pass_d, exp_d;
    logic [CW-1:0] delay_d;

    assign launch  = en_i & primed_q & (stim_i != stim_q);
    assign exp_d   = stim_i ^ INVERT;
    assign delay_d = cnt_q + 1'b1;
    assign match   = resp_i == exp_q;
    assign tmo     = delay_d == CW'(TIMEOUT);
    assign pass_d  = exp_q ? (delay_d >= CW'(RISE_MIN) && delay_d <= CW'(RISE_MAX))
                           : (delay_d >= CW'(FALL_MIN) && delay_d <= CW'(FALL_MAX));

    // A match wins over an abort; a new launch edge always restarts the count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            primed_q     <= 1'b0;
            stim_q       <= 1'b0;
            exp_q        <= 1'b0;
            cnt_q        <= '0;
            valid_q      <= 1'b0;
            rise_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            abort_q      <= 1'b0;
            delay_q      <= '0;
            rise_worst_q <= '0;
            fall_worst_q <= '0;
            err_cnt_q    <= '0;
        end else begin
            stim_q   <= stim_i;
            primed_q <= 1'b1;
            valid_q  <= 1'b0;
            if (state_q == IDLE) begin
                if (launch) begin
                    exp_q   <= exp_d;
                    cnt_q   <= '0;
                    state_q <= MEAS;
                end
            end else if (!en_i) begin
                state_q <= IDLE;
            end else if (match || launch || tmo) begin
                valid_q   <= 1'b1;
                rise_q    <= exp_q;
                delay_q   <= delay_d;
                pass_q    <= match && pass_d;
                abort_q   <= !match && launch;
                timeout_q <= !match && !launch;
                if (match && exp_q && delay_d > rise_worst_q)
                    rise_worst_q <= delay_d;
                if (match && !exp_q && delay_d > fall_worst_q)
                    fall_worst_q <= delay_d;
                if (!(match && pass_d) && err_cnt_q != 8'hFF)
                    err_cnt_q <= err_cnt_q + 8'd1;
                if (launch) begin
                    exp_q <= exp_d;
                    cnt_q <= '0;
                end else begin
                    state_q <= IDLE;
                end
            end else begin
                cnt_q <= delay_d;
            end
        end
    end

    assign busy_o         = state_q == MEAS;
    assign meas_valid_o   = valid_q;
    assign meas_delay_o   = delay_q;
    assign meas_rise_o    = rise_q;
    assign meas_pass_o    = pass_q;
    assign meas_timeout_o = timeout_q;
    assign meas_abort_o   = abort_q;
    assign rise_worst_o   = rise_worst_q;
    assign fall_worst_o   = fall_worst_q;
    assign err_cnt_o      = err_cnt_q;
endmodule

// File: tb/tb_edge_delay_meter.sv
// tb_edge_delay_meter: scoreboard bench driving a non-inverting and an inverting
// meter with the same launch/response stimulus.
module tb_edge_delay_meter;
    localparam int TO = 20;

    typedef struct {
        int at, delay, rise, pass, tmo, abt, rw, fw, err;
    } res_t;

    logic clk, rst_n, en, stim, resp;
    logic busy[2], mv[2], mr[2], mp[2], mt[2], ma[2];
    logic [7:0] md[2], rwo[2], fwo[2], ec[2];

    int n_chk, n_fail, edge_n;
    res_t sbq[2][$];

    bit m_primed, m_prev;
    bit m_active[2], m_exp[2];
    int m_start[2], m_rw[2], m_fw[2], m_err[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        edge_delay_meter #(.TIMEOUT(TO), .INVERT(g == 1)) dut (
            .clk_i(clk), .rst_ni(rst_n), .en_i(en), .stim_i(stim), .resp_i(resp),
            .busy_o(busy[g]), .meas_valid_o(mv[g]), .meas_delay_o(md[g]),
            .meas_rise_o(mr[g]), .meas_pass_o(mp[g]), .meas_timeout_o(mt[g]),
            .meas_abort_o(ma[g]), .rise_worst_o(rwo[g]), .fall_worst_o(fwo[g]),
            .err_cnt_o(ec[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input int act, input int ex);
        n_chk++;
        if (act != ex) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, ex);
        end
    endtask

    task automatic model_reset();
        m_primed = 0;
        m_prev   = 0;
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 0; m_exp[i] = 0; m_start[i] = 0;
            m_rw[i] = 0; m_fw[i] = 0; m_err[i] = 0;
            sbq[i].delete();
        end
    endtask

    // Delay is the number of edges elapsed since the launch edge.
    task automatic model_edge(input bit e, input bit s, input bit r);
        bit launch;
        launch = e && m_primed && (s != m_prev);
        for (int i = 0; i < 2; i++) begin
            if (!m_active[i]) begin
                if (launch) begin
                    m_active[i] = 1; m_start[i] = edge_n; m_exp[i] = s ^ bit'(i);
                end
            end else if (!e) begin
                m_active[i] = 0;
            end else begin
                int d;
                res_t x;
                d = edge_n - m_start[i];
                if (r == m_exp[i] || launch || d == TO) begin
                    x = '{at: edge_n, delay: d, rise: int'(m_exp[i]), pass: 0,
                          tmo: 0, abt: 0, rw: 0, fw: 0, err: 0};
                    if (r == m_exp[i]) begin
                        if (m_exp[i]) begin
                            x.pass = int'(d >= 3 && d <= 7);
                            if (d > m_rw[i]) m_rw[i] = d;
                        end else begin
                            x.pass = int'(d >= 1 && d <= 4);
                            if (d > m_fw[i]) m_fw[i] = d;
                        end
                    end else if (launch) begin
                        x.abt = 1;
                    end else begin
                        x.tmo = 1;
                    end
                    if (x.pass == 0 && m_err[i] < 255) m_err[i]++;
                    x.rw = m_rw[i]; x.fw = m_fw[i]; x.err = m_err[i];
                    sbq[i].push_back(x);
                    if (launch) begin
                        m_start[i] = edge_n; m_exp[i] = s ^ bit'(i);
                    end else begin
                        m_active[i] = 0;
                    end
                end
            end
        end
        m_primed = 1;
        m_prev   = s;
    endtask

    task automatic step(input bit e, input bit s, input bit r);
        @(negedge clk);
        en = e; stim = s; resp = r;
        @(posedge clk);
        edge_n++;
        model_edge(e, s, r);
        #1;
        for (int i = 0; i < 2; i++) cmp($sformatf("inv%0d busy", i), int'(busy[i]), int'(m_active[i]));
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 2; i++)
            cmp($sformatf("%s inv%0d outputs", tag, i),
                int'({busy[i], mv[i], mr[i], mp[i], mt[i], ma[i], md[i], rwo[i], fwo[i], ec[i]}), 0);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mv[i]) begin
                if (sbq[i].size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL inv%0d unexpected result: got delay %0d expected none", i, md[i]);
                end else begin
                    res_t x;
                    x = sbq[i].pop_front();
                    cmp($sformatf("inv%0d edge", i), edge_n, x.at);
                    cmp($sformatf("inv%0d delay", i), int'(md[i]), x.delay);
                    cmp($sformatf("inv%0d rise", i), int'(mr[i]), x.rise);
                    cmp($sformatf("inv%0d pass", i), int'(mp[i]), x.pass);
                    cmp($sformatf("inv%0d timeout", i), int'(mt[i]), x.tmo);
                    cmp($sformatf("inv%0d abort", i), int'(ma[i]), x.abt);
                    cmp($sformatf("inv%0d rise_worst", i), int'(rwo[i]), x.rw);
                    cmp($sformatf("inv%0d fall_worst", i), int'(fwo[i]), x.fw);
                    cmp($sformatf("inv%0d err_cnt", i), int'(ec[i]), x.err);
                end
            end else if (sbq[i].size() != 0) begin
                n_chk++; n_fail++;
                $display("FAIL inv%0d missing result: got no valid expected delay %0d", i, sbq[i][0].delay);
                void'(sbq[i].pop_front());
            end
        end
    end

    initial begin
        bit s, r, e;
        n_chk = 0; n_fail = 0; edge_n = 0;
        en = 0; stim = 0; resp = 0; rst_n = 1;
        model_reset();
        #2 rst_n = 0;
        #1 check_zero("reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        // rise of 5 cycles
        step(1, 0, 0); step(1, 1, 0);
        repeat (4) step(1, 1, 0);
        step(1, 1, 1); step(1, 1, 1);
        // fall of 2, then fall of 6
        step(1, 0, 1); step(1, 0, 1); step(1, 0, 0); step(1, 0, 0);
        step(1, 1, 0); repeat (3) step(1, 1, 0); step(1, 1, 1); step(1, 1, 1);
        step(1, 0, 1); repeat (5) step(1, 0, 1); step(1, 0, 0); step(1, 0, 0);
        // rise stuck low until timeout
        step(1, 1, 0); repeat (TO + 2) step(1, 1, 0);
        step(1, 0, 0); step(1, 0, 0);
        // abort by a falling edge three cycles after launch, response already low
        step(1, 1, 0); step(1, 1, 0); step(1, 1, 0); step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
        // timeout and new edge on the same cycle
        step(1, 1, 0); repeat (TO - 1) step(1, 1, 0); step(1, 0, 0); step(1, 0, 1); step(1, 0, 1);
        // en dropped mid-measurement
        step(1, 1, 1); step(1, 1, 1); step(0, 1, 1); step(0, 1, 0); step(1, 1, 0);
        // reset during a measurement, stim held high across release
        step(1, 0, 0); step(1, 1, 0); step(1, 1, 0);
        @(negedge clk);
        #2 rst_n = 0;
        #1 check_zero("midreset");
        model_reset();
        stim = 1;
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        repeat (3) step(1, 1, 0);
        check_zero("no launch");
        s = 1; r = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(11) == 0) s = ~s;
            if ($urandom_range(3) == 0) r = ~r;
            e = $urandom_range(39) != 0;
            step(e, s, r);
        end
        @(negedge clk); @(negedge clk);
        cmp("leftover inv0", sbq[0].size(), 0);
        cmp("leftover inv1", sbq[1].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
